// File: rtl/instr_fetch_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch_ctrl_if
//  Description : Bus bundle between the fetch sequencer, the instruction
//                memory port and the decode stage.
//  Revision    : 1.0  initial release
// ============================================================================
interface instr_fetch_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
);
  logic              enable_i;
  logic              redirect_i;
  logic [ADDR_W-1:0] redirect_pc_i;
  logic              mem_req_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic              mem_ready_i;
  logic [DATA_W-1:0] mem_data_i;
  logic              instr_valid_o;
  logic [DATA_W-1:0] instr_o;
  logic [ADDR_W-1:0] pc_o;
  logic              instr_ready_i;
  logic [CNT_W-1:0]  fetch_cnt_o;

  // Fetch controller side
  modport slave (
    input  enable_i, redirect_i, redirect_pc_i, mem_ready_i, mem_data_i,
           instr_ready_i,
    output mem_req_o, mem_addr_o, instr_valid_o, instr_o, pc_o, fetch_cnt_o
  );

  // Environment side (memory, decode, branch unit)
  modport master (
    output enable_i, redirect_i, redirect_pc_i, mem_ready_i, mem_data_i,
           instr_ready_i,
    input  mem_req_o, mem_addr_o, instr_valid_o, instr_o, pc_o, fetch_cnt_o
  );
endinterface
`default_nettype wire

// File: rtl/instr_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch_ctrl
//  Description : Fetch sequencer. Owns the fetch PC, issues word-aligned
//                req/ready memory requests, buffers one fetched word for the
//                decode stage and applies branch redirects, squashing any
//                response still in flight.
//  Revision    : 1.0  initial release
// ============================================================================
module instr_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 32,
  parameter int          DATA_W   = 32,
  parameter int          CNT_W    = 16
) (
  input  wire logic          clk_i,
  input  wire logic          rst_i,
  instr_fetch_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_VALID = 2'd2,
    S_FLUSH = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] C_PC_STEP  = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] C_RESET_PC = ADDR_W'(RESET_PC);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_pc;
  logic [ADDR_W-1:0]   w_pc_nxt;
  logic [ADDR_W-1:0]   r_flush_addr;
  logic [ADDR_W-1:0]   w_flush_nxt;
  logic [DATA_W-1:0]   r_instr;
  logic [ADDR_W-1:0]   r_pc_out;
  logic                r_valid;
  logic [CNT_W-1:0]    r_cnt;
  logic                w_capture;
  logic                w_release;
  logic                w_count;
  logic [ADDR_W-1:0]   w_target;
  logic                w_unused_lsbs;

  // Redirect targets are forced to a word boundary; the dropped bits are
  // intentionally ignored.
  assign w_target      = {bus.redirect_pc_i[ADDR_W-1:2], 2'b00};
  assign w_unused_lsbs = ^bus.redirect_pc_i[1:0];

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and datapath control; a redirect outranks every other event
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_flush_nxt = r_flush_addr;
    w_capture   = 1'b0;
    w_release   = 1'b0;
    w_count     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.redirect_i) begin
          w_pc_nxt = w_target;
        end
        if (bus.enable_i) begin
          w_state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        if (bus.redirect_i) begin
          w_pc_nxt = w_target;
          // A request that has not been answered cannot be withdrawn, so
          // keep presenting it from flush_addr until memory responds.
          if (!bus.mem_ready_i) begin
            w_flush_nxt = r_pc;
            w_state_nxt = S_FLUSH;
          end
        end else if (bus.mem_ready_i) begin
          w_capture   = 1'b1;
          w_pc_nxt    = r_pc + C_PC_STEP;
          w_state_nxt = S_VALID;
        end
      end
      S_VALID: begin
        if (bus.redirect_i) begin
          w_pc_nxt    = w_target;
          w_release   = 1'b1;
          w_state_nxt = bus.enable_i ? S_REQ : S_IDLE;
        end else if (bus.instr_ready_i) begin
          w_release   = 1'b1;
          w_count     = 1'b1;
          w_state_nxt = bus.enable_i ? S_REQ : S_IDLE;
        end
      end
      S_FLUSH: begin
        // A redirect here only retargets the PC; the squashed response is
        // still retired normally so no extra request is issued.
        if (bus.redirect_i) begin
          w_pc_nxt = w_target;
        end
        if (bus.mem_ready_i) begin
          w_state_nxt = bus.enable_i ? S_REQ : S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Fetch PC and flush address
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_pc         <= C_RESET_PC;
      r_flush_addr <= '0;
    end else begin
      r_pc         <= w_pc_nxt;
      r_flush_addr <= w_flush_nxt;
    end
  end

  // One-entry output buffer towards decode
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_valid  <= 1'b0;
      r_instr  <= '0;
      r_pc_out <= '0;
    end else if (w_capture) begin
      r_valid  <= 1'b1;
      r_instr  <= bus.mem_data_i;
      r_pc_out <= r_pc;
    end else if (w_release) begin
      r_valid  <= 1'b0;
    end
  end

  // Delivered-instruction counter, sticks at all-ones
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt <= '0;
    end else if (w_count && !(&r_cnt)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign bus.mem_req_o     = (r_state == S_REQ) || (r_state == S_FLUSH);
  assign bus.mem_addr_o    = (r_state == S_FLUSH) ? r_flush_addr : r_pc;
  assign bus.instr_valid_o = r_valid;
  assign bus.instr_o       = r_instr;
  assign bus.pc_o          = r_pc_out;
  assign bus.fetch_cnt_o   = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_fetch_ctrl
//  Description : Randomized self-checking bench for instr_fetch_ctrl with a
//                transaction-level reference model and delivery scoreboard.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_instr_fetch_ctrl;

  localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;
  localparam int          CW     = 4;
  localparam int          CMAX   = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  instr_fetch_ctrl_if #(.ADDR_W(32), .DATA_W(32), .CNT_W(CW)) bus ();

  instr_fetch_ctrl #(
    .RESET_PC(RST_PC), .ADDR_W(32), .DATA_W(32), .CNT_W(CW)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } item_t;

  int    errors = 0;
  int    checks = 0;
  item_t exp_q[$];
  item_t cur;
  bit    running = 1'b0;
  bit    prev_valid = 1'b0;

  // Reference model: next fetch address, outstanding request (live or
  // squashed), buffered word, delivery count.
  logic [31:0] m_pc;
  logic [31:0] m_flush;
  bit          m_busy, m_live, m_full;
  int          m_cnt;

  // Memory responder state
  bit pend;
  int lat;

  function automatic logic [31:0] word_of(logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    m_pc   = RST_PC;
    m_flush = 32'h0;
    m_busy = 1'b0;
    m_live = 1'b1;
    m_full = 1'b0;
    m_cnt  = 0;
  endfunction

  // One clock edge of architectural behaviour
  function automatic void model_step(bit en, bit redir, logic [31:0] tgt,
                                     bit rdy, bit ird);
    logic [31:0] t;
    t = {tgt[31:2], 2'b00};
    if (m_busy && m_live) begin
      if (redir) begin
        if (!rdy) begin
          m_flush = m_pc;
          m_live  = 1'b0;
        end
        m_pc = t;
      end else if (rdy) begin
        exp_q.push_back('{pc: m_pc, instr: word_of(m_pc)});
        m_full = 1'b1;
        m_busy = 1'b0;
        m_pc   = m_pc + 32'd4;
      end
    end else if (m_busy) begin
      if (redir) m_pc = t;
      if (rdy) begin
        m_busy = en;
        m_live = 1'b1;
      end
    end else if (m_full) begin
      if (redir) begin
        m_pc   = t;
        m_full = 1'b0;
        m_busy = en;
      end else if (ird) begin
        m_full = 1'b0;
        if (m_cnt < CMAX) m_cnt++;
        m_busy = en;
      end
      m_live = 1'b1;
    end else begin
      if (redir) m_pc = t;
      m_busy = en;
      m_live = 1'b1;
    end
  endfunction

  // Random stimulus plus a memory with 0..2 cycles of wait
  task automatic drive();
    bus.enable_i      = ($urandom_range(0, 9) < 8);
    bus.redirect_i    = ($urandom_range(0, 11) == 0);
    bus.redirect_pc_i = ($urandom_range(0, 3) == 0) ?
                        (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
    bus.instr_ready_i = ($urandom_range(0, 9) < 6);
    if (bus.mem_req_o) begin
      if (!pend) begin
        pend = 1'b1;
        lat  = $urandom_range(0, 2);
      end
      if (lat == 0) begin
        bus.mem_ready_i = 1'b1;
        bus.mem_data_i  = word_of(bus.mem_addr_o);
        pend = 1'b0;
      end else begin
        lat--;
        bus.mem_ready_i = 1'b0;
        bus.mem_data_i  = $urandom;
      end
    end else begin
      pend = 1'b0;
      bus.mem_ready_i = ($urandom_range(0, 3) == 0);
      bus.mem_data_i  = $urandom;
    end
  endtask

  task automatic run_cycles(int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      drive();
      @(posedge clk);
      model_step(bus.enable_i, bus.redirect_i, bus.redirect_pc_i,
                 bus.mem_ready_i, bus.instr_ready_i);
    end
  endtask

  // Monitor: per-cycle interface checks and scoreboard pops on each new
  // presentation of an instruction
  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
    end else if (running) begin
      chk("mem_req", 32'(bus.mem_req_o), 32'(m_busy));
      chk("mem_addr", bus.mem_addr_o, (m_busy && !m_live) ? m_flush : m_pc);
      chk("instr_valid", 32'(bus.instr_valid_o), 32'(m_full));
      chk("fetch_cnt", 32'(bus.fetch_cnt_o), 32'(m_cnt));
      if (bus.instr_valid_o && !prev_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL scoreboard: unexpected delivery pc %h instr %h",
                   bus.pc_o, bus.instr_o);
          cur = '{pc: bus.pc_o, instr: bus.instr_o};
        end else begin
          cur = exp_q.pop_front();
        end
      end
      if (bus.instr_valid_o) begin
        chk("pc_o", bus.pc_o, cur.pc);
        chk("instr_o", bus.instr_o, cur.instr);
      end
      prev_valid = bus.instr_valid_o;
    end
  end

  initial begin
    bus.enable_i      = 1'b0;
    bus.redirect_i    = 1'b0;
    bus.redirect_pc_i = 32'h0;
    bus.mem_ready_i   = 1'b0;
    bus.mem_data_i    = 32'h0;
    bus.instr_ready_i = 1'b0;
    pend = 1'b0;
    lat  = 0;
    model_reset();

    #1 rst = 1'b1;
    #11;
    chk("rst mem_req", 32'(bus.mem_req_o), 32'h0);
    chk("rst mem_addr", bus.mem_addr_o, RST_PC);
    chk("rst instr_valid", 32'(bus.instr_valid_o), 32'h0);
    chk("rst instr_o", bus.instr_o, 32'h0);
    chk("rst pc_o", bus.pc_o, 32'h0);
    chk("rst fetch_cnt", 32'(bus.fetch_cnt_o), 32'h0);
    @(posedge clk);
    #3 rst = 1'b0;
    running = 1'b1;

    run_cycles(3000);

    // Counter must have saturated by now given the delivery rate
    @(negedge clk);
    chk("cnt saturated", 32'(bus.fetch_cnt_o), 32'(CMAX));

    // Hit an asynchronous reset while a live request is outstanding
    begin
      int guard;
      bit found;
      found = 1'b0;
      for (guard = 0; guard < 200; guard++) begin
        if (bus.mem_req_o && m_live) begin
          found = 1'b1;
          break;
        end
        drive();
        @(posedge clk);
        model_step(bus.enable_i, bus.redirect_i, bus.redirect_pc_i,
                   bus.mem_ready_i, bus.instr_ready_i);
        @(negedge clk);
      end
      checks++;
      if (!found) begin
        errors++;
        $display("FAIL find_req: no live request within 200 cycles");
      end
    end
    #2 rst = 1'b1;
    #1;
    chk("async mem_req", 32'(bus.mem_req_o), 32'h0);
    chk("async instr_valid", 32'(bus.instr_valid_o), 32'h0);
    chk("async fetch_cnt", 32'(bus.fetch_cnt_o), 32'h0);
    chk("async mem_addr", bus.mem_addr_o, RST_PC);
    model_reset();
    exp_q.delete();
    pend = 1'b0;
    bus.mem_ready_i = 1'b0;
    @(posedge clk);
    #3 rst = 1'b0;

    run_cycles(1500);

    @(negedge clk);
    running = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instr_fetch_ctrl.md
Name: instr_fetch_ctrl

Overview:
Fetch sequencer placed between the program counter and the instruction memory. It owns the fetch PC and issues word-aligned requests over a multi-cycle req/ready memory handshake. Fetched words are held in a one-entry output buffer until the decode stage accepts them. Branch/jump redirects are applied with in-flight responses squashed.

Parameters:
RESET_PC, 32'h0000_0000, fetch address loaded on reset
ADDR_W, 32, address width
DATA_W, 32, instruction width
CNT_W, 16, width of the fetched-instruction counter

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  asynchronous reset, active-high
enable_i  input  1  allow new memory requests
redirect_i  input  1  branch/jump taken, single-cycle pulse
redirect_pc_i  input  ADDR_W  redirect target
mem_req_o  output  1  memory request valid
mem_addr_o  output  ADDR_W  byte address of request, always word-aligned
mem_ready_i  input  1  memory response valid this cycle
mem_data_i  input  DATA_W  instruction word, valid with mem_ready_i
instr_valid_o  output  1  instr_o/pc_o hold an unconsumed instruction
instr_o  output  DATA_W  buffered instruction
pc_o  output  ADDR_W  address of instr_o
instr_ready_i  input  1  decode accepts instruction
fetch_cnt_o  output  CNT_W  instructions delivered, saturating

Behaviour:
- Reset (async, immediate): state IDLE, pc_q=RESET_PC, mem_req_o=0, instr_valid_o=0, instr_o=0, pc_o=0, fetch_cnt_o=0. mem_addr_o=pc_q at all times except in FLUSH.
- States: IDLE, REQ, VALID, FLUSH. mem_req_o=1 exactly in REQ and FLUSH.
- IDLE: if enable_i, next state is REQ.
- REQ: hold mem_req_o and mem_addr_o stable until mem_ready_i.
  - On mem_ready_i without redirect_i: instr_o<=mem_data_i, pc_o<=pc_q, instr_valid_o<=1, pc_q<=pc_q+4 (mod 2^ADDR_W, so 32'hFFFF_FFFC wraps to 0), next state VALID.
  - Minimum latency, request to instr_valid_o: 1 cycle after mem_ready_i.
- VALID: instr_valid_o, instr_o and pc_o stay stable until instr_ready_i=1. Handshake cycle: instr_valid_o<=0, fetch_cnt_o increments (saturates at all-ones), next state REQ if enable_i, else IDLE.
- Redirect, with target = {redirect_pc_i[ADDR_W-1:2], 2'b00}. It has priority over every other event in the same cycle.
  - In IDLE or VALID: pc_q<=target, instr_valid_o<=0 (a pending instruction is discarded, not counted, even if instr_ready_i=1 that cycle), next state REQ if enable_i, else IDLE.
  - In REQ with mem_ready_i=1: response discarded, pc_q<=target, next state REQ (new request next cycle).
  - In REQ with mem_ready_i=0: the outstanding request cannot be withdrawn. Latch the old address into flush_addr, pc_q<=target, next state FLUSH.
- FLUSH: mem_addr_o=flush_addr, mem_req_o=1.
  - On mem_ready_i: data discarded, next state REQ if enable_i, else IDLE.
  - Redirect in FLUSH only updates pc_q. The last redirect wins.
- enable_i=0 never aborts REQ or FLUSH. It only suppresses starting a new request from IDLE or VALID.
- mem_ready_i outside REQ/FLUSH is ignored.
- At most one request is outstanding.

Test Plan:
- Reset, enable_i=1, memory with 2-cycle latency returning word=addr, instr_ready_i=1 -> pc_o sequence 0,4,8,12 with instr_o equal; fetch_cnt_o=4 after four handshakes; mem_addr_o stable during each wait.
- Backpressure: instr_ready_i=0 for 5 cycles while in VALID at pc 0x8 -> instr_o/pc_o unchanged, mem_req_o=0, no pc_q advance; release -> next request at 0xC.
- Redirect to 0x103 in REQ with mem_ready_i=0 -> FLUSH keeps mem_addr_o at old address until ready, data dropped; next request at 0x100; first delivered pc_o=0x100.
- Redirect coincident with mem_ready_i and with instr_ready_i in VALID -> no delivery, fetch_cnt_o unchanged, next request at target.
- RESET_PC=32'hFFFF_FFF8 -> delivers 0xFFFFFFF8, 0xFFFFFFFC, 0x0. Force fetch_cnt_o to all-ones, then one more handshake -> value stays all-ones.
- Assert rst_i mid-REQ (not clock-aligned) -> mem_req_o, instr_valid_o, fetch_cnt_o drop immediately; after release, fetch restarts at RESET_PC.
